// File: rtl/ram_responder.sv
// Byte-addressed RAM slave answering MFA/MOC handshakes with big-endian byte,
// halfword, word and two-beat doubleword transfers moved one byte per cycle.
module ram_responder #(
    parameter int ADDR_W = 8,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MFA,
    input  logic              L,
    input  logic              D,
    input  logic [1:0]        WB,
    input  logic              S,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int WCW   = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((WAIT > 0) ? WAIT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE,
        S_GAP,
        S_HOLD
    } state_t;

    state_t            state, nextState;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] baseAddr, curAddr;
    logic              isLoad, isDouble, signExt, beat;
    logic [1:0]        sizeSel;
    logic [31:0]       storeData;
    logic [23:0]       loadShift;
    logic [WCW-1:0]    waitCnt;
    logic [1:0]        byteIdx, lastIdx, bytePos;
    logic [7:0]        rdByte, wrByte;
    logic [31:0]       loadWord, loadExt;
    logic              lastByte, mocNext;

    // Doubleword beats are always four bytes, whatever WB says.
    always_comb begin
        lastIdx = 2'd1;
        if (isDouble || sizeSel[1])
            lastIdx = 2'd3;
        else if (sizeSel[0])
            lastIdx = 2'd0;
    end

    always_comb begin
        curAddr  = baseAddr + ADDR_W'(byteIdx);
        bytePos  = lastIdx - byteIdx;
        rdByte   = mem[curAddr];
        wrByte   = storeData[{bytePos, 3'b000} +: 8];
        lastByte = (byteIdx == lastIdx);
        loadWord = {loadShift, rdByte};
        case (lastIdx)
            2'd0:    loadExt = signExt ? {{24{loadWord[7]}}, loadWord[7:0]}
                                       : {24'h0, loadWord[7:0]};
            2'd1:    loadExt = signExt ? {{16{loadWord[15]}}, loadWord[15:0]}
                                       : {16'h0, loadWord[15:0]};
            default: loadExt = loadWord;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: if (MFA) nextState = (WAIT == 0) ? S_XFER : S_WAIT;
            S_WAIT: if (waitCnt == WAIT_LAST) nextState = S_XFER;
            S_XFER: if (lastByte) nextState = S_DONE;
            S_DONE: begin
                if (isDouble && !beat)
                    nextState = S_GAP;
                else if (MFA)
                    nextState = S_HOLD;
                else
                    nextState = S_IDLE;
            end
            S_GAP:  nextState = S_XFER;
            S_HOLD: if (!MFA) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
        mocNext = (nextState == S_DONE) || (nextState == S_HOLD);
    end

    // Request capture, beat sequencing and the registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baseAddr  <= '0;
            isLoad    <= 1'b0;
            isDouble  <= 1'b0;
            signExt   <= 1'b0;
            sizeSel   <= 2'b00;
            storeData <= 32'h0;
            loadShift <= 24'h0;
            waitCnt   <= '0;
            byteIdx   <= 2'd0;
            beat      <= 1'b0;
            DataOut   <= 32'h0;
            MOC       <= 1'b0;
        end else begin
            MOC <= mocNext;
            case (state)
                S_IDLE: begin
                    if (MFA) begin
                        baseAddr  <= Address;
                        isLoad    <= L;
                        isDouble  <= D;
                        sizeSel   <= WB;
                        signExt   <= S;
                        storeData <= DataIn;
                        waitCnt   <= '0;
                        byteIdx   <= 2'd0;
                        beat      <= 1'b0;
                    end
                end
                S_WAIT: waitCnt <= waitCnt + WCW'(1);
                S_XFER: begin
                    loadShift <= loadWord[23:0];
                    byteIdx   <= lastByte ? 2'd0 : byteIdx + 2'd1;
                    if (isLoad && lastByte)
                        DataOut <= loadExt;
                end
                S_GAP: begin
                    storeData <= DataIn;
                    baseAddr  <= baseAddr + ADDR_W'(4);
                    byteIdx   <= 2'd0;
                    beat      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; a reset only stops further writes via the state.
    always_ff @(posedge clk) begin
        if (state == S_XFER && !isLoad)
            mem[curAddr] <= wrByte;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (ADDR_W=8, WAIT=2); cycle
// counts number the cycle that begins at the MFA-sampling edge as cycle 1.
module tb_ram_responder;

    logic        clk;
    logic        reset;
    logic        MFA, L, D, S;
    logic [1:0]  WB;
    logic [7:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;

    int passCount = 0;
    int checkCount = 0;

    ram_responder #(.ADDR_W(8), .WAIT(2)) dut (
        .clk(clk), .reset(reset), .MFA(MFA), .L(L), .D(D), .WB(WB), .S(S),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MOC(MOC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Drives one request; inputs are scrambled after the first cycle so that
    // anything not ignored outside IDLE corrupts the result.
    task automatic do_access(input logic l, input logic d, input logic [1:0] wb,
                             input logic s, input logic [7:0] addr,
                             input logic [31:0] din, input logic [31:0] din2,
                             input bit dropEarly, input int holdCycles,
                             output int cyc1, output int cyc2, output logic gapMoc,
                             output logic [31:0] dout1, output logic [31:0] dout2,
                             output int holdHigh, output logic mocAfter);
        int cyc;
        bit seen;
        @(negedge clk);
        MFA = 1'b1; L = l; D = d; WB = wb; S = s; Address = addr; DataIn = din;
        cyc = 0; cyc1 = -1; cyc2 = 0; gapMoc = 1'b0;
        dout1 = 32'h0; dout2 = 32'h0; holdHigh = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                L = ~l; D = ~d; WB = ~wb; S = ~s; Address = ~addr;
                DataIn = 32'hDEADBEEF;
                if (dropEarly) MFA = 1'b0;
            end
            if (MOC === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            cyc1  = cyc;
            dout1 = DataOut;
        end
        if (d) begin
            cyc2 = -1;
            if (seen) begin
                DataIn = din2;
                @(negedge clk);
                cyc++;
                gapMoc = MOC;
                seen = 1'b0;
                while (!seen && cyc < 80) begin
                    @(negedge clk);
                    cyc++;
                    DataIn = 32'hDEADBEEF;
                    if (MOC === 1'b1) seen = 1'b1;
                end
                if (seen) begin
                    cyc2  = cyc;
                    dout2 = DataOut;
                end
            end
        end
        repeat (holdCycles) begin
            @(negedge clk);
            if (MOC === 1'b1) holdHigh++;
        end
        MFA = 1'b0;
        @(negedge clk);
        mocAfter = MOC;
    endtask

    task automatic load_byte(input logic [7:0] addr, input logic s,
                             output logic [31:0] dout, output int cyc);
        int c2, hh;
        logic gm, ma;
        logic [31:0] d2;
        do_access(1'b1, 1'b0, 2'b01, s, addr, 32'h0, 32'h0, 1'b0, 0,
                  cyc, c2, gm, dout, d2, hh, ma);
    endtask

    task automatic store(input logic [1:0] wb, input logic [7:0] addr,
                         input logic [31:0] din, output int cyc);
        int c2, hh;
        logic gm, ma;
        logic [31:0] d1, d2;
        do_access(1'b0, 1'b0, wb, 1'b0, addr, din, 32'h0, 1'b0, 0,
                  cyc, c2, gm, d1, d2, hh, ma);
    endtask

    task automatic load(input logic [1:0] wb, input logic s, input logic [7:0] addr,
                        output logic [31:0] dout, output int cyc);
        int c2, hh;
        logic gm, ma;
        logic [31:0] d2;
        do_access(1'b1, 1'b0, wb, s, addr, 32'h0, 32'h0, 1'b0, 0,
                  cyc, c2, gm, dout, d2, hh, ma);
    endtask

    task automatic test_reset();
        reset = 1'b1; MFA = 1'b0; L = 1'b0; D = 1'b0; WB = 2'b10; S = 1'b0;
        Address = 8'h00; DataIn = 32'h0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (MOC !== 1'b0) $display("[TB] FAIL reset_moc: got %b expected 0", MOC);
        else passCount++;
        checkCount++;
        if (DataOut !== 32'h0) $display("[TB] FAIL reset_dataout: got %h expected 00000000", DataOut);
        else passCount++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        int c;
        logic [31:0] v;
        store(2'b10, 8'h10, 32'h11223344, c);
        checkCount++;
        if (c !== 7) $display("[TB] FAIL word_store_moc: got cycle %0d expected 7", c);
        else passCount++;
        load(2'b11, 1'b0, 8'h10, v, c);
        checkCount++;
        if (c !== 7) $display("[TB] FAIL word_load_moc: got cycle %0d expected 7", c);
        else passCount++;
        checkCount++;
        if (v !== 32'h11223344) $display("[TB] FAIL word_load_data: got %h expected 11223344", v);
        else passCount++;
        load_byte(8'h10, 1'b0, v, c);
        checkCount++;
        if (v !== 32'h00000011) $display("[TB] FAIL byte10_data: got %h expected 00000011", v);
        else passCount++;
        checkCount++;
        if (c !== 4) $display("[TB] FAIL byte_load_moc: got cycle %0d expected 4", c);
        else passCount++;
    endtask

    task automatic test_sign_extend();
        int c;
        logic [31:0] v;
        load_byte(8'h13, 1'b1, v, c);
        checkCount++;
        if (v !== 32'h00000044) $display("[TB] FAIL byte13_sext: got %h expected 00000044", v);
        else passCount++;
        checkCount++;
        if (c !== 4) $display("[TB] FAIL byte13_moc: got cycle %0d expected 4", c);
        else passCount++;
        load(2'b00, 1'b0, 8'h11, v, c);
        checkCount++;
        if (v !== 32'h00002233) $display("[TB] FAIL half11_data: got %h expected 00002233", v);
        else passCount++;
        checkCount++;
        if (c !== 5) $display("[TB] FAIL half_moc: got cycle %0d expected 5", c);
        else passCount++;
        store(2'b01, 8'h10, 32'h12345680, c);
        load_byte(8'h10, 1'b1, v, c);
        checkCount++;
        if (v !== 32'hFFFFFF80) $display("[TB] FAIL byte80_sext: got %h expected ffffff80", v);
        else passCount++;
        load_byte(8'h10, 1'b0, v, c);
        checkCount++;
        if (v !== 32'h00000080) $display("[TB] FAIL byte80_zext: got %h expected 00000080", v);
        else passCount++;
        load(2'b00, 1'b1, 8'h10, v, c);
        checkCount++;
        if (v !== 32'hFFFF8022) $display("[TB] FAIL half10_sext: got %h expected ffff8022", v);
        else passCount++;
    endtask

    task automatic test_doubleword();
        int c1, c2, hh;
        logic gm, ma;
        logic [31:0] d1, d2, v;
        do_access(1'b0, 1'b1, 2'b10, 1'b0, 8'h20, 32'hAAAA5555, 32'h0F0F0F0F, 1'b0, 3,
                  c1, c2, gm, d1, d2, hh, ma);
        checkCount++;
        if (c1 !== 7) $display("[TB] FAIL dw_moc1: got cycle %0d expected 7", c1);
        else passCount++;
        checkCount++;
        if (gm !== 1'b0) $display("[TB] FAIL dw_gap_moc: got %b expected 0", gm);
        else passCount++;
        checkCount++;
        if (c2 !== 13) $display("[TB] FAIL dw_moc2: got cycle %0d expected 13", c2);
        else passCount++;
        checkCount++;
        if (hh !== 3) $display("[TB] FAIL dw_hold: got %0d high cycles expected 3", hh);
        else passCount++;
        checkCount++;
        if (ma !== 1'b0) $display("[TB] FAIL dw_release: got %b expected 0", ma);
        else passCount++;
        load(2'b10, 1'b0, 8'h24, v, c1);
        checkCount++;
        if (v !== 32'h0F0F0F0F) $display("[TB] FAIL dw_word24: got %h expected 0f0f0f0f", v);
        else passCount++;
        load(2'b10, 1'b0, 8'h20, v, c1);
        checkCount++;
        if (v !== 32'hAAAA5555) $display("[TB] FAIL dw_word20: got %h expected aaaa5555", v);
        else passCount++;
        do_access(1'b1, 1'b1, 2'b01, 1'b1, 8'h20, 32'h0, 32'h0, 1'b0, 0,
                  c1, c2, gm, d1, d2, hh, ma);
        checkCount++;
        if (d1 !== 32'hAAAA5555) $display("[TB] FAIL dw_load_beat0: got %h expected aaaa5555", d1);
        else passCount++;
        checkCount++;
        if (d2 !== 32'h0F0F0F0F) $display("[TB] FAIL dw_load_beat1: got %h expected 0f0f0f0f", d2);
        else passCount++;
    endtask

    task automatic test_wrap();
        int c;
        logic [31:0] v;
        store(2'b00, 8'hFF, 32'h1234BEEF, c);
        load_byte(8'hFF, 1'b0, v, c);
        checkCount++;
        if (v !== 32'h000000BE) $display("[TB] FAIL wrap_byteff: got %h expected 000000be", v);
        else passCount++;
        load_byte(8'h00, 1'b0, v, c);
        checkCount++;
        if (v !== 32'h000000EF) $display("[TB] FAIL wrap_byte00: got %h expected 000000ef", v);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        int c;
        logic [31:0] v;
        logic [7:0] expBytes [4];
        expBytes[0] = 8'hCA; expBytes[1] = 8'hFE; expBytes[2] = 8'h00; expBytes[3] = 8'h00;
        store(2'b10, 8'h40, 32'h00000000, c);
        @(negedge clk);
        MFA = 1'b1; L = 1'b0; D = 1'b0; WB = 2'b10; S = 1'b0;
        Address = 8'h40; DataIn = 32'hCAFEBABE;
        repeat (5) @(negedge clk);
        reset = 1'b1; MFA = 1'b0;
        #1;
        checkCount++;
        if (MOC !== 1'b0) $display("[TB] FAIL midreset_moc: got %b expected 0", MOC);
        else passCount++;
        checkCount++;
        if (DataOut !== 32'h0) $display("[TB] FAIL midreset_dataout: got %h expected 00000000", DataOut);
        else passCount++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkCount++;
        if (MOC !== 1'b0) $display("[TB] FAIL midreset_moc_after: got %b expected 0", MOC);
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            load_byte(8'h40 + 8'(i), 1'b0, v, c);
            checkCount++;
            if (v !== {24'h0, expBytes[i]})
                $display("[TB] FAIL midreset_byte%0d: got %h expected %h", i, v, {24'h0, expBytes[i]});
            else passCount++;
        end
        checkCount++;
        if (c !== 4) $display("[TB] FAIL midreset_next_moc: got cycle %0d expected 4", c);
        else passCount++;
    endtask

    task automatic test_drop_mfa();
        int c1, c2, hh;
        logic gm, ma;
        logic [31:0] d1, d2;
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h0, 1'b1, 0,
                  c1, c2, gm, d1, d2, hh, ma);
        checkCount++;
        if (c1 !== 7) $display("[TB] FAIL drop_moc: got cycle %0d expected 7", c1);
        else passCount++;
        checkCount++;
        if (d1 !== 32'h80223344) $display("[TB] FAIL drop_data: got %h expected 80223344", d1);
        else passCount++;
        checkCount++;
        if (ma !== 1'b0) $display("[TB] FAIL drop_moc_width: got %b expected 0", ma);
        else passCount++;
    endtask

    initial begin
        $display("[TB] ram_responder directed test start");
        test_reset();
        test_word();
        test_sign_extend();
        test_doubleword();
        test_wrap();
        test_reset_mid();
        test_drop_mfa();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width; the memory holds 2^ADDR_W bytes.
REQ-002 The block SHALL have parameter WAIT, default 2, giving the access wait cycles before the first byte moves (0 allowed).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port MFA, input, 1 bit: memory function active (request).
REQ-006 The block SHALL have port L, input, 1 bit: 1 = load, 0 = store.
REQ-007 The block SHALL have port D, input, 1 bit: doubleword transfer, taking priority over WB.
REQ-008 The block SHALL have port WB, input, 2 bits: access size, 10 = word, 01 = byte, 00 = halfword, 11 = word.
REQ-009 The block SHALL have port S, input, 1 bit: sign-extend byte/halfword loads.
REQ-010 The block SHALL have port Address, input, ADDR_W bits: starting byte address.
REQ-011 The block SHALL have port DataIn, input, 32 bits: store data.
REQ-012 The block SHALL have port DataOut, output, 32 bits: load data.
REQ-013 The block SHALL have port MOC, output, 1 bit: memory operation complete.

Function
REQ-014 States SHALL be IDLE, WAIT, XFER, DONE, GAP, HOLD.
REQ-015 In IDLE with MFA=1 the block SHALL latch Address, L, D, WB, S and DataIn, then enter WAIT (or XFER if WAIT=0); in IDLE, MOC=0.
REQ-016 WAIT SHALL last exactly WAIT cycles, then enter XFER.
REQ-017 XFER SHALL move one byte per cycle: 1 for byte, 2 for halfword, 4 for word and per doubleword beat, then enter DONE.
REQ-018 Byte order SHALL be big-endian: byte k at address A+k maps to word bits [31-8k:24-8k], halfword bits [15-8k:8-8k], and byte bits [7:0].
REQ-019 Loads SHALL zero-extend byte/halfword into DataOut, or sign-extend when the latched S=1; DataOut SHALL update only in DONE of a load and hold until the next load's DONE.
REQ-020 Byte addresses SHALL wrap modulo 2^ADDR_W; unaligned addresses are legal.
REQ-021 MOC SHALL rise WAIT+n+1 cycles after the edge that sampled MFA (n = bytes in the beat).
REQ-022 Doubleword beat 0 SHALL use address A and end with a one-cycle MOC pulse in DONE, followed by GAP.
REQ-023 GAP SHALL last one cycle with MOC=0 and SHALL re-sample DataIn for a store; beat 1 SHALL then run XFER at address A+4 (wrapped) without a second WAIT.
REQ-024 After the final beat, if MFA=1 the block SHALL enter HOLD, keeping MOC=1 until MFA is sampled 0, then return to IDLE with MOC=0.
REQ-025 If MFA=0 during the final DONE, MOC SHALL be high that one cycle only, and the next state SHALL be IDLE.
REQ-026 MFA deasserting before the final DONE SHALL NOT abort the transfer; a new request SHALL be accepted only from IDLE.
REQ-027 Inputs other than MFA SHALL be ignored outside IDLE (and outside GAP for DataIn).

Reset
REQ-028 Reset SHALL force state IDLE, MOC=0, DataOut=0 and clear counters, regardless of clk.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset mid-transfer SHALL leave bytes already written in place and perform no further writes.

Verification
REQ-031 Word store 0x11223344 to address 0x10, then word load 0x10 with WAIT=2 -> MOC rises 7 cycles after MFA sampled; DataOut=0x11223344; byte 0x10 holds 0x11.
REQ-032 Byte load from 0x13 with S=1 after the REQ-031 store -> DataOut=0x00000044 and MOC rises 4 cycles after request; byte 0x10 with memory 0x80 -> 0xFFFFFF80.
REQ-033 Doubleword store at 0x20 with DataIn 0xAAAA5555, then 0x0F0F0F0F during GAP -> MOC pulse at cycle 7, second MOC at cycle 13 held until MFA drops; word load 0x24 returns 0x0F0F0F0F.
REQ-034 Halfword store 0xBEEF at 0xFF with ADDR_W=8 -> byte 0xFF=0xBE and byte 0x00=0xEF (wrap).
REQ-035 Reset asserted during the third XFER cycle of a word store -> MOC=0, IDLE immediately; exactly two bytes changed.
REQ-036 Drop MFA during WAIT -> transfer completes; MOC high exactly one cycle; then IDLE.
